// File: rtl/voice_slot_sched_if.sv
// Handshake between the frame scheduler and the shared voice datapath.
// The scheduler drives start/voice; the datapath answers with done.
interface voice_slot_sched_if #(
  parameter int VW = 3
);
  logic          start;
  logic [VW-1:0] voice;
  logic          done;

  modport master (output start, output voice, input done);
  modport slave  (input start, input voice, output done);
endinterface

// File: rtl/voice_slot_sched.sv
// Sample-frame scheduler: on every prescaler tick, walks the enabled voices in
// ascending order and hands each one to the shared datapath, one at a time.
module voice_slot_sched #(
  parameter int CLK_DIV = 1000,
  parameter int DIV_W   = 10,
  parameter int VOICES  = 8,
  parameter int VW      = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [VOICES-1:0] voice_en,
  input  logic              ovr_clr,
  voice_slot_sched_if.master dp,
  output logic              sample_tick,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("voice_slot_sched: CLK_DIV must be >= 2");
  end
  if ((2 ** DIV_W) < CLK_DIV) begin : g_bad_div_w
    $error("voice_slot_sched: DIV_W too narrow for CLK_DIV");
  end
  if (VOICES < 2) begin : g_bad_voices
    $error("voice_slot_sched: VOICES must be >= 2");
  end
  if ((2 ** VW) < VOICES) begin : g_bad_vw
    $error("voice_slot_sched: VW too narrow for VOICES");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [VW-1:0]    IDX_LAST = VW'(VOICES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT,
    FIN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  count;
  logic [VW-1:0]     idx;
  logic [VW-1:0]     idx_next;
  logic [VOICES-1:0] mask;
  logic [VOICES-1:0] mask_next;
  logic              overrun_set;

  assign sample_tick = en && (count == DIV_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == DIV_LAST) begin
        count <= '0;
      end else begin
        count <= count + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      idx   <= '0;
      mask  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      mask  <= mask_next;
    end
  end

  // The mask is captured once per frame so mid-frame VOICE_EN edits cannot
  // reorder or skip voices that are already being walked.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    mask_next  = mask;
    unique case (state)
      IDLE: begin
        if (sample_tick) begin
          mask_next  = voice_en;
          idx_next   = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (mask[idx]) begin
          state_next = ISSUE;
        end else if (idx == IDX_LAST) begin
          state_next = FIN;
        end else begin
          idx_next = idx + VW'(1);
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (dp.done) begin
          if (idx == IDX_LAST) begin
            state_next = FIN;
          end else begin
            idx_next   = idx + VW'(1);
            state_next = SCAN;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dp.start   = (state == ISSUE);
  assign dp.voice   = idx;
  assign busy       = (state != IDLE);
  assign frame_done = (state == FIN);

  // A tick landing on a running frame is dropped; flag it so software can see
  // the datapath is too slow for the sample rate.
  assign overrun_set = sample_tick && (state != IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_voice_slot_sched.sv
// Directed bench for voice_slot_sched: table-driven frame vectors plus
// hand-written overrun, mid-frame reset and mid-frame enable-drop sequences.
module tb_voice_slot_sched;

  localparam int CLK_DIV = 20;
  localparam int DIV_W   = 5;
  localparam int VOICES  = 4;
  localparam int VW      = 2;

  logic              clk = 1'b0;
  logic              clr;
  logic              en;
  logic [VOICES-1:0] voice_en;
  logic              ovr_clr;
  logic              sample_tick;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  int num_checks = 0;
  int num_errors = 0;

  voice_slot_sched_if #(.VW(VW)) dp_if ();

  voice_slot_sched #(
    .CLK_DIV(CLK_DIV),
    .DIV_W  (DIV_W),
    .VOICES (VOICES),
    .VW     (VW)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .voice_en   (voice_en),
    .ovr_clr    (ovr_clr),
    .dp         (dp_if.master),
    .sample_tick(sample_tick),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      mask;
    logic            toggle;
    logic [3:0]      toggle_mask;
    int              n_start;
    logic [3:0][7:0] start_off;
    logic [3:0][1:0] start_voice;
    int              fd_off;
  } frame_vec_t;

  frame_vec_t tbl [3];

  task automatic applyStimulus(input logic c, input logic e, input logic [3:0] ve,
                               input logic d, input logic oc);
    clr        = c;
    en         = e;
    voice_en   = ve;
    dp_if.done = d;
    ovr_clr    = oc;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    num_checks++;
    if (actual != expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitTick(input int limit);
    logic found;
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (sample_tick) found = 1'b1;
    end
    checkOutput("wait_for_tick", int'(found), 1);
  endtask

  // Entered on the tick cycle (offset 0); walks offsets 1..20 while acting as
  // the datapath, answering each START with DONE two cycles later.
  task automatic runFrame(input int vec_id, input logic [3:0] next_mask, input logic drop_en);
    frame_vec_t v;
    int         last_start;
    logic       exp_start;
    int         exp_voice;
    logic       e;
    logic [3:0] ve;
    v          = tbl[vec_id];
    last_start = -100;
    e          = en;
    ve         = voice_en;
    for (int off = 1; off <= 20; off++) begin
      @(negedge clk);
      exp_start = 1'b0;
      exp_voice = 0;
      for (int k = 0; k < v.n_start; k++) begin
        if (int'(v.start_off[k]) == off) begin
          exp_start = 1'b1;
          exp_voice = int'(v.start_voice[k]);
        end
      end
      checkOutput($sformatf("v%0d_start@%0d", vec_id, off), int'(dp_if.start), int'(exp_start));
      if (exp_start) begin
        checkOutput($sformatf("v%0d_voice@%0d", vec_id, off), int'(dp_if.voice), exp_voice);
      end
      checkOutput($sformatf("v%0d_frame_done@%0d", vec_id, off), int'(frame_done),
                  (off == v.fd_off) ? 1 : 0);
      checkOutput($sformatf("v%0d_busy@%0d", vec_id, off), int'(busy),
                  (off <= v.fd_off) ? 1 : 0);
      checkOutput($sformatf("v%0d_tick@%0d", vec_id, off), int'(sample_tick),
                  ((off == 20) && !drop_en) ? 1 : 0);
      if (dp_if.start) last_start = off;
      if (v.toggle && off == 4) ve = v.toggle_mask;
      if (off == 19) ve = next_mask;
      if (drop_en && off == 1) e = 1'b0;
      applyStimulus(1'b0, e, ve, (off == last_start + 2), 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int last_start;

    tbl[0].mask        = 4'b1111;
    tbl[0].toggle      = 1'b0;
    tbl[0].toggle_mask = 4'b0000;
    tbl[0].n_start     = 4;
    tbl[0].start_off   = {8'd14, 8'd10, 8'd6, 8'd2};
    tbl[0].start_voice = {2'd3, 2'd2, 2'd1, 2'd0};
    tbl[0].fd_off      = 17;

    tbl[1].mask        = 4'b1010;
    tbl[1].toggle      = 1'b1;
    tbl[1].toggle_mask = 4'b0101;
    tbl[1].n_start     = 2;
    tbl[1].start_off   = {8'd0, 8'd0, 8'd8, 8'd3};
    tbl[1].start_voice = {2'd0, 2'd0, 2'd3, 2'd1};
    tbl[1].fd_off      = 11;

    tbl[2].mask        = 4'b0000;
    tbl[2].toggle      = 1'b0;
    tbl[2].toggle_mask = 4'b0000;
    tbl[2].n_start     = 0;
    tbl[2].start_off   = '0;
    tbl[2].start_voice = '0;
    tbl[2].fd_off      = 5;

    // Reset with the prescaler disabled.
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_start", int'(dp_if.start), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_voice", int'(dp_if.voice), 0);
    checkOutput("rst_tick", int'(sample_tick), 0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checkOutput($sformatf("en0_tick@%0d", i), int'(sample_tick), 0);
      checkOutput($sformatf("en0_busy@%0d", i), int'(busy), 0);
    end

    // Back-to-back frames from the vector table.
    applyStimulus(1'b0, 1'b1, tbl[0].mask, 1'b0, 1'b0);
    waitTick(40);
    runFrame(0, tbl[1].mask, 1'b0);
    runFrame(1, tbl[2].mask, 1'b0);
    runFrame(2, 4'b1111, 1'b0);

    // Overrun: datapath never answers, so later ticks hit a busy frame.
    for (int off = 1; off <= 46; off++) begin
      @(negedge clk);
      if (off == 2) begin
        checkOutput("ovr_first_start", int'(dp_if.start), 1);
        checkOutput("ovr_first_voice", int'(dp_if.voice), 0);
      end
      if (off >= 3) begin
        checkOutput($sformatf("ovr_no_start@%0d", off), int'(dp_if.start), 0);
        checkOutput($sformatf("ovr_busy@%0d", off), int'(busy), 1);
      end
      if (off == 20) begin
        checkOutput("ovr_tick20", int'(sample_tick), 1);
        checkOutput("ovr_before_set", int'(overrun), 0);
      end
      if (off == 21) begin
        checkOutput("ovr_set", int'(overrun), 1);
        checkOutput("ovr_voice_held", int'(dp_if.voice), 0);
      end
      if (off == 40) checkOutput("ovr_tick40", int'(sample_tick), 1);
      if (off == 41) checkOutput("ovr_set_beats_clear", int'(overrun), 1);
      if (off == 45) checkOutput("ovr_still_set", int'(overrun), 1);
      if (off == 46) checkOutput("ovr_cleared", int'(overrun), 0);
      applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0, (off == 40) || (off == 45));
    end

    // Reset the stuck frame, then abort a fresh frame mid-way with clr.
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("clr_abort_busy", int'(busy), 0);
    checkOutput("clr_abort_overrun", int'(overrun), 0);
    checkOutput("clr_abort_voice", int'(dp_if.voice), 0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
    waitTick(40);
    last_start = -100;
    for (int off = 1; off <= 27; off++) begin
      @(negedge clk);
      checkOutput($sformatf("clr_fd@%0d", off), int'(frame_done), 0);
      if (off == 2 || off == 6) begin
        checkOutput($sformatf("clr_start@%0d", off), int'(dp_if.start), 1);
        checkOutput($sformatf("clr_voice@%0d", off), int'(dp_if.voice), (off == 2) ? 0 : 1);
      end
      if (off == 8) begin
        checkOutput("clr_mid_busy", int'(busy), 0);
        checkOutput("clr_mid_voice", int'(dp_if.voice), 0);
      end
      if (off >= 8) begin
        checkOutput($sformatf("clr_no_start@%0d", off), int'(dp_if.start), 0);
        checkOutput($sformatf("clr_tick@%0d", off), int'(sample_tick), (off == 27) ? 1 : 0);
      end
      if (dp_if.start) last_start = off;
      applyStimulus((off == 7), 1'b1, 4'b1111, (off == last_start + 2), 1'b0);
    end

    // Drop the enable right after the tick: frame still finishes, no new ticks.
    runFrame(0, 4'b1111, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("en_drop_tick@%0d", i), int'(sample_tick), 0);
      checkOutput($sformatf("en_drop_busy@%0d", i), int'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/voice_slot_sched.md
Name: voice_slot_sched

Overview:
- Sample-frame scheduler that shares one time-multiplexed voice datapath among VOICES voice slots.
- An internal prescaler, a modulo-CLK_DIV counter, generates the sample-rate tick.
- On each tick the block walks the enabled voices in ascending order. For each enabled voice it issues a one-cycle START with the voice index, then waits for the datapath's DONE before moving to the next voice.
- Sits between the sample clock domain logic and the shared oscillator/envelope datapath.

Parameters:
- CLK_DIV, 1000: clock cycles per sample period; must be >= 2.
- DIV_W, 10: prescaler counter width; must satisfy 2^DIV_W >= CLK_DIV.
- VOICES, 8: number of voice slots; must be >= 2.
- VW, 3: voice index width; must satisfy 2^VW >= VOICES.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- CLR  in  1  reset, synchronous, active-high
- EN  in  1  prescaler enable
- VOICE_EN  in  VOICES  per-voice enable mask, sampled at frame start
- DONE  in  1  datapath completion strobe for the current voice
- OVR_CLR  in  1  clears OVERRUN
- SAMPLE_TICK  out  1  one-cycle sample-rate strobe
- START  out  1  one-cycle request to datapath
- VOICE  out  VW  index of the voice being issued or served
- BUSY  out  1  frame in progress
- FRAME_DONE  out  1  one-cycle strobe, all voices of the frame handled
- OVERRUN  out  1  sticky: tick arrived while BUSY

Behaviour:
- Reset (CLR=1 at an edge):
  - Prescaler count=0, state=IDLE, voice index=0, latched mask=0, OVERRUN=0.
  - START, FRAME_DONE and BUSY are 0 in the following cycle.
  - CLR mid-frame aborts the frame immediately; no further START or FRAME_DONE for that frame.
- Prescaler:
  - When EN=1, count advances 0..CLK_DIV-1 and wraps to 0. When EN=0, count holds.
  - SAMPLE_TICK = EN & (count==CLK_DIV-1). This is a combinational decode.
- States: IDLE, SCAN, ISSUE, WAIT, FIN.
  - START, VOICE, BUSY and FRAME_DONE are decoded from registered state only; there is no input-to-output combinational path.
- IDLE:
  - On SAMPLE_TICK: latch mask<=VOICE_EN, idx<=0, go to SCAN.
  - Changes to VOICE_EN during a frame are ignored.
- SCAN (one voice checked per cycle):
  - If mask[idx]=1: go to ISSUE.
  - Else if idx==VOICES-1: go to FIN.
  - Else: idx<=idx+1, stay in SCAN.
- ISSUE:
  - START=1 for exactly one cycle, VOICE=idx; then go to WAIT.
  - DONE is ignored in the ISSUE cycle.
- WAIT:
  - Holds until DONE=1. There is no timeout.
  - On DONE: if idx==VOICES-1 go to FIN, else idx<=idx+1 and go to SCAN.
- FIN:
  - FRAME_DONE=1 for one cycle, then go to IDLE.
- BUSY = (state != IDLE).
- VOICE:
  - Equals idx at all times and holds its last value in IDLE.
  - Reset value 0.
- Overrun:
  - SAMPLE_TICK while state != IDLE sets OVERRUN at the next edge.
  - That tick is dropped; the current frame continues unaffected.
  - OVR_CLR=1 clears OVERRUN. If set and clear occur in the same cycle, set wins.
- EN=0 mid-frame: the frame runs to completion; no new ticks are generated.
- Latency for all-zero mask: tick at cycle t gives FRAME_DONE at t+VOICES+1 and no START.
- Latency with first voice enabled: first START at t+2.

Test Plan:
- CLR asserted for 2 cycles, EN=0 -> START, FRAME_DONE, BUSY, OVERRUN, VOICE all 0; SAMPLE_TICK never asserts.
- CLK_DIV=20, VOICES=4, EN=1, VOICE_EN=4'b1111, DONE pulsed 2 cycles after each START, tick at t:
  - START at t+2, t+6, t+10, t+14 with VOICE=0,1,2,3.
  - FRAME_DONE at t+17; BUSY from t+1 through t+17.
  - Next SAMPLE_TICK at t+20.
- Same setup, VOICE_EN=4'b1010:
  - START at t+3 (VOICE=1) and t+8 (VOICE=3); FRAME_DONE at t+11.
  - Toggling VOICE_EN to 4'b0101 at t+4 has no effect.
- VOICE_EN=0 -> no START; FRAME_DONE at t+5; BUSY high t+1..t+5.
- Overrun: DONE held low, ticks at t and t+20:
  - OVERRUN=1 from t+21; no second frame starts and VOICE stays 0.
  - OVR_CLR pulsed together with the tick at t+40 -> OVERRUN remains 1.
  - OVR_CLR alone at t+45 -> 0 at t+46.
- CLR mid-frame: CLR at t+7 with mask 4'b1111 -> state IDLE, BUSY=0, prescaler restarts, no FRAME_DONE.
  - EN=0 mid-frame -> frame still completes and FRAME_DONE appears; no new ticks.
